mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single core-side memory bus between the fetch stage (instruction reads) and the memory stage (data loads/stores). It sits between the pipeline's fetch and memory stages and the cache/bus interface. It holds a grant for a whole burst and routes the response back to the owning requester. Stall generation in the pipeline is driven by its per-requester `ready`/`last` outputs.

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: fetch and data stages share one core-side bus.
// Optional round-robin tie-breaking via MEM_ARB_ROUND_ROBIN_EN; fixed data priority otherwise.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  // Fetch requester
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2:0]          i_size,
  input  logic [3:0]          i_len,
  output logic                i_ready,
  output logic                i_last,
  output logic [DATA_W-1:0]   i_rdata,
  // Data requester
  input  logic                d_valid,
  input  logic                d_is_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [3:0]          d_len,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic                d_last,
  output logic [DATA_W-1:0]   d_rdata,
  // Core-side bus
  output logic                c_valid,
  output logic                c_is_write,
  output logic [ADDR_W-1:0]   c_addr,
  output logic [2:0]          c_size,
  output logic [3:0]          c_len,
  output logic [DATA_W/8-1:0] c_strobe,
  output logic [DATA_W-1:0]   c_wdata,
  input  logic                c_ready,
  input  logic                c_last,
  input  logic [DATA_W-1:0]   c_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD
  } arbState_t;

  arbState_t stateQ, stateD;
  logic      pickData;
  logic      burstDone;

  assign burstDone = c_ready && c_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the data requester won the most recent grant; reset favours data.
  logic lastServedDataQ, lastServedDataD;

  always_comb begin
    pickData = d_valid && (!i_valid || !lastServedDataQ);
  end

  always_comb begin
    lastServedDataD = lastServedDataQ;
    if (stateQ == StIdle && (i_valid || d_valid)) begin
      lastServedDataD = pickData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastServedDataQ <= 1'b0;
    end else begin
      lastServedDataQ <= lastServedDataD;
    end
  end
`else
  always_comb begin
    pickData = d_valid;
  end
`endif

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (pickData) begin
          stateD = StGrantD;
        end else if (i_valid) begin
          stateD = StGrantI;
        end
      end
      StGrantI, StGrantD: begin
        // Grant is held until the bus flags the final beat, even if valid drops.
        if (burstDone) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    c_valid    = 1'b0;
    c_is_write = 1'b0;
    c_addr     = '0;
    c_size     = '0;
    c_len      = '0;
    c_strobe   = '0;
    c_wdata    = '0;
    i_ready    = 1'b0;
    i_last     = 1'b0;
    i_rdata    = '0;
    d_ready    = 1'b0;
    d_last     = 1'b0;
    d_rdata    = '0;
    busy       = 1'b0;
    unique case (stateQ)
      StGrantI: begin
        busy    = 1'b1;
        c_valid = i_valid;
        c_addr  = i_addr;
        c_size  = i_size;
        c_len   = i_len;
        i_ready = c_ready;
        i_last  = c_last;
        i_rdata = c_rdata;
      end
      StGrantD: begin
        busy       = 1'b1;
        c_valid    = d_valid;
        c_is_write = d_is_write;
        c_addr     = d_addr;
        c_size     = d_size;
        c_len      = d_len;
        c_strobe   = d_strobe;
        c_wdata    = d_wdata;
        d_ready    = c_ready;
        d_last     = c_last;
        d_rdata    = c_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic                clk;
  logic                reset;
  logic                i_valid;
  logic [ADDR_W-1:0]   i_addr;
  logic [2:0]          i_size;
  logic [3:0]          i_len;
  logic                i_ready;
  logic                i_last;
  logic [DATA_W-1:0]   i_rdata;
  logic                d_valid;
  logic                d_is_write;
  logic [ADDR_W-1:0]   d_addr;
  logic [2:0]          d_size;
  logic [3:0]          d_len;
  logic [DATA_W/8-1:0] d_strobe;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_ready;
  logic                d_last;
  logic [DATA_W-1:0]   d_rdata;
  logic                c_valid;
  logic                c_is_write;
  logic [ADDR_W-1:0]   c_addr;
  logic [2:0]          c_size;
  logic [3:0]          c_len;
  logic [DATA_W/8-1:0] c_strobe;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_ready;
  logic                c_last;
  logic [DATA_W-1:0]   c_rdata;
  logic                busy;

  int nChecks = 0;
  int nFails  = 0;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_addr     (i_addr),
    .i_size     (i_size),
    .i_len      (i_len),
    .i_ready    (i_ready),
    .i_last     (i_last),
    .i_rdata    (i_rdata),
    .d_valid    (d_valid),
    .d_is_write (d_is_write),
    .d_addr     (d_addr),
    .d_size     (d_size),
    .d_len      (d_len),
    .d_strobe   (d_strobe),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_last     (d_last),
    .d_rdata    (d_rdata),
    .c_valid    (c_valid),
    .c_is_write (c_is_write),
    .c_addr     (c_addr),
    .c_size     (c_size),
    .c_len      (c_len),
    .c_strobe   (c_strobe),
    .c_wdata    (c_wdata),
    .c_ready    (c_ready),
    .c_last     (c_last),
    .c_rdata    (c_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic expData [3];
  int   readyCnt;

  initial begin
    reset = 1'b1;
    i_valid = 0; i_addr = '0; i_size = 3'd3; i_len = '0;
    d_valid = 0; d_is_write = 0; d_addr = '0; d_size = 3'd3; d_len = '0;
    d_strobe = '0; d_wdata = '0;
    c_ready = 0; c_last = 0; c_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkEq("reset busy", busy, 0);
    checkEq("reset c_valid", c_valid, 0);
    checkEq("reset i_ready", i_ready, 0);

    // Lone single-beat fetch
    tick();
    i_valid = 1; i_addr = 64'h8000_0000; i_len = 0;
    #1;
    checkEq("fetch arb latency c_valid", c_valid, 0);
    tick();
    checkEq("fetch c_valid", c_valid, 1);
    checkEq("fetch c_addr", c_addr, 64'h8000_0000);
    checkEq("fetch c_is_write", c_is_write, 0);
    checkEq("fetch i_ready before beat", i_ready, 0);
    tick();
    c_ready = 1; c_last = 1; c_rdata = 64'h1234;
    #1;
    checkEq("fetch i_ready", i_ready, 1);
    checkEq("fetch i_last", i_last, 1);
    checkEq("fetch i_rdata", i_rdata, 64'h1234);
    checkEq("fetch d_ready", d_ready, 0);
    tick();
    i_valid = 0; c_ready = 0; c_last = 0;
    #1;
    checkEq("fetch done busy", busy, 0);
    checkEq("fetch done i_ready", i_ready, 0);

    // Single-beat store
    tick();
    d_valid = 1; d_is_write = 1; d_addr = 64'h10; d_strobe = 8'hFF;
    d_wdata = 64'hDEAD_BEEF; d_len = 0;
    tick();
    c_ready = 1; c_last = 1; c_rdata = 64'h55;
    #1;
    checkEq("store c_valid", c_valid, 1);
    checkEq("store c_is_write", c_is_write, 1);
    checkEq("store c_addr", c_addr, 64'h10);
    checkEq("store c_wdata", c_wdata, 64'hDEAD_BEEF);
    checkEq("store c_strobe", c_strobe, 8'hFF);
    checkEq("store d_ready", d_ready, 1);
    checkEq("store i_ready", i_ready, 0);
    checkEq("store i_rdata", i_rdata, 0);
    tick();
    d_valid = 0; c_ready = 0; c_last = 0;
    #1;
    checkEq("store done busy", busy, 0);

    // Four-beat fetch burst; owner drops valid on beat 1 but keeps the grant
    tick();
    i_valid = 1; i_addr = 64'h2000; i_len = 4'd3;
    tick();
    readyCnt = 0;
    for (int b = 0; b < 4; b++) begin
      c_ready = 1; c_last = (b == 3); i_valid = (b != 1);
      #1;
      checkEq("burst busy", busy, 1);
      checkEq("burst c_valid", c_valid, (b != 1));
      checkEq("burst i_last", i_last, (b == 3));
      checkEq("burst c_len", c_len, 4'd3);
      if (i_ready) readyCnt++;
      tick();
    end
    i_valid = 0; c_ready = 0; c_last = 0;
    #1;
    checkEq("burst ready count", readyCnt, 4);
    checkEq("burst bubble c_valid", c_valid, 0);
    checkEq("burst bubble busy", busy, 0);

    // Tie across three single-beat bursts
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expData[0] = 1; expData[1] = 0; expData[2] = 1;
`else
    expData[0] = 1; expData[1] = 1; expData[2] = 1;
`endif
    tick();
    i_valid = 1; i_addr = 64'h100; i_len = 0;
    d_valid = 1; d_is_write = 0; d_addr = 64'h200; d_len = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      c_ready = 1; c_last = 1; c_rdata = 64'(k + 1);
      #1;
      checkEq("tie d_ready", d_ready, expData[k]);
      checkEq("tie i_ready", i_ready, !expData[k]);
      checkEq("tie c_addr", c_addr, expData[k] ? 64'h200 : 64'h100);
      tick();
      c_ready = 0; c_last = 0;
      if (k == 2) begin
        i_valid = 0; d_valid = 0;
      end
      #1;
      checkEq("tie bubble c_valid", c_valid, 0);
    end

    // Late data request during a four-beat fetch
    tick();
    i_valid = 1; i_addr = 64'h3000; i_len = 4'd3;
    tick();
    for (int b = 0; b < 4; b++) begin
      c_ready = 1; c_last = (b == 3);
      if (b == 1) begin
        d_valid = 1; d_is_write = 1; d_addr = 64'h300; d_len = 0;
        d_wdata = 64'hCAFE; d_strobe = 8'h0F;
      end
      #1;
      checkEq("late c_addr", c_addr, 64'h3000);
      checkEq("late d_ready", d_ready, 0);
      checkEq("late i_ready", i_ready, 1);
      tick();
    end
    i_valid = 0; c_ready = 0; c_last = 0;
    #1;
    checkEq("late bubble c_valid", c_valid, 0);
    tick();
    checkEq("late d c_valid", c_valid, 1);
    checkEq("late d c_addr", c_addr, 64'h300);
    checkEq("late d c_is_write", c_is_write, 1);
    checkEq("late d c_strobe", c_strobe, 8'h0F);
    c_ready = 1; c_last = 1;
    #1;
    checkEq("late d_last", d_last, 1);
    tick();
    d_valid = 0; c_ready = 0; c_last = 0;

    // Reset asserted on beat 2 of a fetch burst
    tick();
    i_valid = 1; i_addr = 64'h4000; i_len = 4'd3;
    tick();
    c_ready = 1; c_last = 0;
    tick();
    reset = 1;
    #1;
    checkEq("rst beat2 busy", busy, 1);
    tick();
    reset = 0; c_ready = 0;
    #1;
    checkEq("rst busy", busy, 0);
    checkEq("rst c_valid", c_valid, 0);
    tick();
    checkEq("post rst c_valid", c_valid, 1);
    checkEq("post rst c_addr", c_addr, 64'h4000);
    c_ready = 1; c_last = 1;
    #1;
    checkEq("post rst i_last", i_last, 1);
    tick();
    i_valid = 0; c_ready = 0; c_last = 0;
    #1;
    checkEq("post rst done busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
